// File: rtl/counter_sched_pkg.sv
// Shared types for the two-requester counter run scheduler: FSM states,
// requester index and the default datapath width.
package counter_sched_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef logic req_idx_t;

  function automatic logic [1:0] idx_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/counter8_dp.sv
// Shared up-counter datapath: synchronous clear has priority over increment.
module counter8_dp #(
  parameter int WIDTH = counter_sched_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_run_sched.sv
// Round-robin scheduler sharing one up-counter between two requesters that
// each ask for a run of N counts, gated by the tile enable.
module counter_run_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit LAST_INIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] count,
  output logic             count_oe
);

  state_e           state_q;
  req_idx_t         winner_q;
  req_idx_t         last_q;
  logic [WIDTH-1:0] target_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;

  req_idx_t         arb_pick;
  logic [WIDTH-1:0] win_len;
  logic [WIDTH:0]   count_inc;
  logic             run_hit;
  logic             dp_clr;
  logic             dp_inc;

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    arb_pick = 1'b0;
    if (req == 2'b11) begin
      arb_pick = ~last_q;
    end else if (req[1]) begin
      arb_pick = 1'b1;
    end
  end

  assign win_len   = winner_q ? len1 : len0;
  // One extra bit so a full-scale run length compares without wrapping.
  assign count_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
  assign run_hit   = (count_inc == {1'b0, target_q});
  assign dp_clr    = (state_q == LOAD);
  assign dp_inc    = (state_q == RUN) && req[winner_q] && ena;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      last_q   <= LAST_INIT;
      target_q <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|req) begin
            winner_q <= arb_pick;
            last_q   <= arb_pick;
            gnt_q    <= idx_onehot(arb_pick);
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          target_q <= win_len;
          if (win_len == '0) begin
            done_q  <= gnt_q;
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // A withdrawn request aborts silently; the counter keeps its value.
          if (!req[winner_q]) begin
            gnt_q   <= 2'b00;
            state_q <= IDLE;
          end else if (ena && run_hit) begin
            done_q  <= gnt_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          gnt_q   <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  counter8_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (dp_clr),
    .inc_i  (dp_inc),
    .count_o(count)
  );

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign count_oe = (state_q == RUN);

endmodule

// File: tb/tb_counter_run_sched.sv
// Scoreboard bench for counter_run_sched: a run-level model predicts each
// completion or abort; a monitor pops and compares as the DUT reports them.
module tb_counter_run_sched;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         ena;
  logic [1:0]   req;
  logic [W-1:0] len0;
  logic [W-1:0] len1;
  logic [1:0]   gnt;
  logic         busy;
  logic [1:0]   done;
  logic [W-1:0] count;
  logic         count_oe;

  counter_run_sched #(
    .WIDTH(W),
    .LAST_INIT(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .req     (req),
    .len0    (len0),
    .len1    (len1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .count_oe(count_oe)
  );

  typedef enum int {EV_DONE = 0, EV_ABORT = 1} ev_e;
  typedef struct {
    ev_e kind;
    int  idx;
    int  cnt;
    int  lat;
    int  oe;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_m;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: compares every completion and abort against the scoreboard.
  int         cyc = 0;
  int         grant_cyc = 0;
  int         oe_cnt = 0;
  logic [1:0] prev_gnt = 2'b00;
  logic [1:0] run_gnt = 2'b00;
  logic       prev_busy = 1'b0;
  logic       prev_done = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_gnt  = 2'b00;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        oe_cnt    = 0;
      end else begin
        cyc++;
        if (prev_gnt == 2'b00 && gnt != 2'b00) begin
          grant_cyc = cyc;
          run_gnt   = gnt;
          oe_cnt    = 0;
          check("gnt_onehot", int'(gnt == 2'b01 || gnt == 2'b10), 1);
        end
        if (count_oe) oe_cnt++;
        if (done != 2'b00) begin
          if (sb.size() == 0) begin
            check("unexpected_done", int'(done), 0);
          end else begin
            e = sb.pop_front();
            check("event_kind_done", int'(EV_DONE), int'(e.kind));
            check("done_who", int'(done), (e.idx == 0) ? 1 : 2);
            check("done_count", int'(count), e.cnt);
            check("done_latency", cyc - grant_cyc, e.lat);
            check("run_oe_cycles", oe_cnt, e.oe);
          end
        end else if (prev_busy && !busy && !prev_done) begin
          if (sb.size() == 0) begin
            check("unexpected_abort", int'(run_gnt), 0);
          end else begin
            e = sb.pop_front();
            check("event_kind_abort", int'(EV_ABORT), int'(e.kind));
            check("abort_who", int'(run_gnt), (e.idx == 0) ? 1 : 2);
            check("abort_count", int'(count), e.cnt);
            check("abort_gnt", int'(gnt), 0);
          end
        end
        prev_gnt  = gnt;
        prev_busy = busy;
        prev_done = (done != 2'b00);
      end
    end
  end

  // Reference model: grant order from the round-robin rule, then each run's
  // outcome from its length and the single stall/abort event of the round.
  task automatic predict(input logic [1:0] pat, input int l0, input int l1,
                         input int mode, input int param, input int stall_n);
    int   order[$];
    int   first;
    int   len;
    int   st;
    bit   armed;
    exp_t e;
    if (pat == 2'b11) begin
      first = (last_m == 0) ? 1 : 0;
      order = '{first, 1 - first};
    end else begin
      order = '{(pat == 2'b10) ? 1 : 0};
    end
    last_m = order[order.size() - 1];
    armed  = 1'b1;
    foreach (order[k]) begin
      len = (order[k] == 0) ? l0 : l1;
      if (mode == 1 && armed && param < len) begin
        armed = 1'b0;
        e = '{kind: EV_ABORT, idx: order[k], cnt: param, lat: 0, oe: 0};
      end else begin
        st = 0;
        if (mode == 2 && armed && param < len) begin
          armed = 1'b0;
          st    = stall_n;
        end
        // LOAD cycle, then one RUN cycle per count plus stalled cycles.
        e = '{kind: EV_DONE, idx: order[k], cnt: len, lat: len + 1 + st, oe: len + st};
      end
      sb.push_back(e);
    end
  endtask

  // mode: 0 plain, 1 withdraw the granted req at count==param, 2 stall ena.
  task automatic run_round(input logic [1:0] pat, input int l0, input int l1,
                           input int mode, input int param, input int stall_n);
    int t;
    int stall_left;
    bit armed;
    bit finished;
    predict(pat, l0, l1, mode, param, stall_n);
    len0       = W'(l0);
    len1       = W'(l1);
    req        = pat;
    armed      = 1'b1;
    stall_left = 0;
    finished   = 1'b0;
    for (t = 0; t < 1500 && !finished; t++) begin
      @(negedge clk);
      if (done != 2'b00) req = req & ~done;
      if (mode == 1 && armed && count_oe && int'(count) == param) begin
        req   = req & ~gnt;
        armed = 1'b0;
      end
      if (mode == 2 && armed && count_oe && int'(count) == param) begin
        stall_left = stall_n;
        armed      = 1'b0;
      end
      if (stall_left > 0) begin
        ena = 1'b0;
        stall_left--;
      end else if (count_oe) begin
        ena = 1'b1;
      end else begin
        ena = 1'($urandom_range(0, 1));
      end
      if (req == 2'b00 && !busy) finished = 1'b1;
    end
    if (!finished) check("round_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    req  = 2'b00;
    ena  = 1'b0;
    len0 = '0;
    len1 = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_oe", int'(count_oe), 0);
    rst    = 1'b0;
    last_m = 1;
    sb.delete();
  endtask

  initial begin
    int  pat;
    int  l0;
    int  l1;
    bit  seen;
    rst = 1'b1;
    apply_reset();

    // Single run of 3, count holds afterwards.
    run_round(2'b01, 3, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("t1_count_hold", int'(count), 3);
    check("t1_gnt_idle", int'(gnt), 0);

    // Simultaneous requests: requester 0 first, then requester 1.
    apply_reset();
    run_round(2'b11, 2, 4, 0, 0, 0);

    // Zero-length run goes LOAD -> DONE.
    apply_reset();
    run_round(2'b10, 0, 0, 0, 0, 0);
    check("t3_count_zero", int'(count), 0);

    // Two-cycle ena stall mid-run.
    apply_reset();
    run_round(2'b01, 5, 0, 2, 2, 2);

    // Abort at count 50.
    apply_reset();
    run_round(2'b01, 200, 0, 1, 50, 0);
    repeat (2) @(negedge clk);
    check("t5_count_hold", int'(count), 50);
    check("t5_gnt", int'(gnt), 0);
    check("t5_busy", int'(busy), 0);

    // Reset mid-run, then a full-scale run without wrap.
    apply_reset();
    len0 = 8'd255;
    ena  = 1'b1;
    req  = 2'b01;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (count_oe && count == 8'd128) seen = 1'b1;
    end
    check("t6_reached_128", int'(seen), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_gnt", int'(gnt), 0);
    check("t6_async_busy", int'(busy), 0);
    check("t6_async_count", int'(count), 0);
    check("t6_async_oe", int'(count_oe), 0);
    check("t6_async_done", int'(done), 0);
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    rst    = 1'b0;
    last_m = 1;
    run_round(2'b01, 255, 0, 0, 0, 0);
    check("t6_no_wrap", int'(count), 255);

    // Randomized rounds against the model, no reset in between.
    for (int r = 0; r < 40; r++) begin
      pat = $urandom_range(1, 3);
      l0  = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 12);
      l1  = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 12);
      run_round(2'(pat), l0, l1, $urandom_range(0, 2), $urandom_range(0, 12),
                $urandom_range(1, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
